trap_delay_line: RTL and testbench

//  Parametrised multi-tap circular delay line for the trapezoidal filter datapath.

---
 rtl/trap_delay_line_if.sv | 31 +++
 rtl/trap_delay_line.sv | 152 +++++++++++++++
 tb/tb_trap_delay_line.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_delay_line_if.sv
// rtl/trap_delay_line_if.sv - configuration, sample and tap bundle for trap_delay_line
interface trap_delay_line_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          cfg_load;
    logic [AW-1:0] cfg_kdelay;
    logic [AW-1:0] cfg_ldelay;
    logic          cfg_err;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_k;
    logic [DW-1:0] out_l;
    logic [DW-1:0] out_kl;
    logic          out_primed;
    logic [AW-1:0] fill_count;

    // Sample/config source side
    modport master (
        output cfg_load, cfg_kdelay, cfg_ldelay, in_valid, in_data,
        input  cfg_err, out_valid, out_x, out_k, out_l, out_kl, out_primed, fill_count
    );

    // Delay line side
    modport slave (
        input  cfg_load, cfg_kdelay, cfg_ldelay, in_valid, in_data,
        output cfg_err, out_valid, out_x, out_k, out_l, out_kl, out_primed, fill_count
    );
endinterface

// File: rtl/trap_delay_line.sv
// rtl/trap_delay_line.sv - multi-tap circular delay line producing x[n], x[n-k], x[n-l], x[n-k-l]
module trap_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int K_DEFAULT  = 10,
    parameter int L_DEFAULT  = 20
) (
    input  logic               clk,
    input  logic               aresetn,
    trap_delay_line_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0]    ST_FILL  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW:0]   MAX_SUM  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

    // Sample storage; never reset, stale words are hidden by the fill gating
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         k_q, k_d;
    logic [AW-1:0]         l_q, l_d;
    logic [AW-1:0]         fill_q, fill_d;
    logic [0:0]            state_q, state_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  out_valid_q, out_valid_d;
    logic                  primed_q, primed_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] tk_q, tk_d;
    logic [DATA_WIDTH-1:0] tl_q, tl_d;
    logic [DATA_WIDTH-1:0] tkl_q, tkl_d;

    logic [AW:0]           cfg_sum;
    logic                  cfg_ok;
    logic                  cfg_accept;
    logic [AW-1:0]         k_eff;
    logic [AW-1:0]         l_eff;
    logic [AW:0]           kl_eff;
    logic [AW-1:0]         fill_eff;
    logic [0:0]            state_eff;
    logic [AW-1:0]         rd_k;
    logic [AW-1:0]         rd_l;
    logic [AW-1:0]         rd_kl;

    // Validate a config request and derive the delays/fill seen by a same-cycle sample
    always_comb begin
        cfg_sum    = {1'b0, bus.cfg_kdelay} + {1'b0, bus.cfg_ldelay};
        cfg_ok     = (bus.cfg_kdelay != '0) && (bus.cfg_ldelay != '0) && (cfg_sum <= MAX_SUM);
        cfg_accept = bus.cfg_load && cfg_ok;
        k_eff      = cfg_accept ? bus.cfg_kdelay : k_q;
        l_eff      = cfg_accept ? bus.cfg_ldelay : l_q;
        fill_eff   = cfg_accept ? '0 : fill_q;
        state_eff  = cfg_accept ? ST_FILL : state_q;
        kl_eff     = {1'b0, k_eff} + {1'b0, l_eff};
        // k+l never exceeds DEPTH-1, so dropping the top bit keeps the modular address right
        rd_k       = wr_ptr_q - k_eff;
        rd_l       = wr_ptr_q - l_eff;
        rd_kl      = wr_ptr_q - kl_eff[AW-1:0];
    end

    // Next-state: config update, pointer/fill advance, gated tap capture and fill/run FSM
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        l_d         = l_q;
        fill_d      = fill_q;
        state_d     = state_q;
        cfg_err_d   = cfg_err_q;
        primed_d    = primed_q;
        x_d         = x_q;
        tk_d        = tk_q;
        tl_d        = tl_q;
        tkl_d       = tkl_q;
        out_valid_d = bus.in_valid;

        if (bus.cfg_load) begin
            if (cfg_ok) begin
                k_d       = bus.cfg_kdelay;
                l_d       = bus.cfg_ldelay;
                fill_d    = '0;
                state_d   = ST_FILL;
                cfg_err_d = 1'b0;
                primed_d  = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (bus.in_valid) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + AW'(1);
            x_d      = bus.in_data;
            tk_d     = (fill_eff < k_eff)           ? '0 : mem_q[rd_k];
            tl_d     = (fill_eff < l_eff)           ? '0 : mem_q[rd_l];
            tkl_d    = ({1'b0, fill_eff} < kl_eff)  ? '0 : mem_q[rd_kl];
            // Primed reflects the state before this sample, so it rises with sample k+l
            primed_d = (state_eff == ST_RUN);
            if ((state_eff == ST_FILL) && ({1'b0, fill_eff} == kl_eff - (AW+1)'(1))) begin
                state_d = ST_RUN;
            end
        end
    end

    // Sample write into the circular buffer
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Control and tap registers with asynchronous clear
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            k_q         <= AW'(K_DEFAULT);
            l_q         <= AW'(L_DEFAULT);
            fill_q      <= '0;
            state_q     <= ST_FILL;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            x_q         <= '0;
            tk_q        <= '0;
            tl_q        <= '0;
            tkl_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            l_q         <= l_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
            x_q         <= x_d;
            tk_q        <= tk_d;
            tl_q        <= tl_d;
            tkl_q       <= tkl_d;
        end
    end

    assign bus.cfg_err    = cfg_err_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = x_q;
    assign bus.out_k      = tk_q;
    assign bus.out_l      = tl_q;
    assign bus.out_kl     = tkl_q;
    assign bus.out_primed = primed_q;
    assign bus.fill_count = fill_q;
endmodule

// File: tb/tb_trap_delay_line.sv
// tb/tb_trap_delay_line.sv - scoreboard bench for trap_delay_line
module tb_trap_delay_line;
    typedef struct {
        logic [15:0] x;
        logic [15:0] k;
        logic [15:0] l;
        logic [15:0] kl;
        logic        primed;
        int          cyc;
    } exp_t;

    logic clk;
    logic aresetn;
    int   checks;
    int   errors;
    int   cyc;
    int   mk;
    int   ml;
    exp_t q[$];
    logic [15:0] hist[$];
    exp_t mon_e;
    logic [15:0] lx, lk, ll, lkl;

    trap_delay_line_if #(.DW(16), .AW(4)) bus ();

    trap_delay_line #(
        .DATA_WIDTH(16),
        .DEPTH     (16),
        .K_DEFAULT (5),
        .L_DEFAULT (10)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected taps from the sample history since the last reset or accepted load
    function automatic exp_t model_exp(input logic [15:0] v);
        exp_t e;
        int   n;
        n        = hist.size();
        e.x      = v;
        e.k      = (n >= mk)      ? hist[n-mk]      : 16'h0;
        e.l      = (n >= ml)      ? hist[n-ml]      : 16'h0;
        e.kl     = (n >= mk + ml) ? hist[n-mk-ml]   : 16'h0;
        e.primed = (n >= mk + ml);
        e.cyc    = cyc + 1;
        return e;
    endfunction

    task automatic sample(input logic [15:0] v);
        exp_t e;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        e = model_exp(v);
        q.push_back(e);
        hist.push_back(v);
    endtask

    // Hand-computed expectation for the ramp test
    task automatic sample_hand(input logic [15:0] v, input logic [15:0] ek, input logic [15:0] el,
                               input logic [15:0] ekl, input logic ep);
        exp_t e;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        e        = model_exp(v);
        e.k      = ek;
        e.l      = el;
        e.kl     = ekl;
        e.primed = ep;
        q.push_back(e);
        hist.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.cfg_load = 1'b0;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic chk_fill(input string name);
        int f;
        f = (hist.size() > 15) ? 15 : hist.size();
        check(name, 32'(bus.fill_count), 32'(f));
    endtask

    task automatic cfg(input int k, input int l, input logic with_v, input logic [15:0] v);
        logic accept;
        @(posedge clk); #1;
        bus.cfg_load   = 1'b1;
        bus.cfg_kdelay = 4'(k);
        bus.cfg_ldelay = 4'(l);
        bus.in_valid   = with_v;
        bus.in_data    = v;
        accept = (k >= 1) && (l >= 1) && (k + l <= 15);
        if (accept) begin
            mk = k;
            ml = l;
            hist.delete();
        end
        if (with_v) begin
            q.push_back(model_exp(v));
            hist.push_back(v);
        end
        @(posedge clk); #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("cfg_err", 32'(bus.cfg_err), 32'(!accept));
        chk_fill("cfg_fill");
        if (accept) check("cfg_primed_clear", 32'(bus.out_primed), 32'(with_v ? 1'b0 : 1'b0));
    endtask

    task automatic chk_all_zero(input string name);
        check({name, "_valid"},  32'(bus.out_valid),  0);
        check({name, "_x"},      32'(bus.out_x),      0);
        check({name, "_k"},      32'(bus.out_k),      0);
        check({name, "_l"},      32'(bus.out_l),      0);
        check({name, "_kl"},     32'(bus.out_kl),     0);
        check({name, "_primed"}, 32'(bus.out_primed), 0);
        check({name, "_err"},    32'(bus.cfg_err),    0);
        check({name, "_fill"},   32'(bus.fill_count), 0);
    endtask

    // Monitor: pop on every out_valid, otherwise taps must hold the last delivered values
    always @(negedge clk) begin
        if (!aresetn) begin
            lx  = '0;
            lk  = '0;
            ll  = '0;
            lkl = '0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 0);
            end else begin
                mon_e = q.pop_front();
                check("out_x",      32'(bus.out_x),      32'(mon_e.x));
                check("out_k",      32'(bus.out_k),      32'(mon_e.k));
                check("out_l",      32'(bus.out_l),      32'(mon_e.l));
                check("out_kl",     32'(bus.out_kl),     32'(mon_e.kl));
                check("out_primed", 32'(bus.out_primed), 32'(mon_e.primed));
                check("latency",    32'(cyc),            32'(mon_e.cyc));
                lx  = mon_e.x;
                lk  = mon_e.k;
                ll  = mon_e.l;
                lkl = mon_e.kl;
            end
        end else begin
            check("hold_x",  32'(bus.out_x),  32'(lx));
            check("hold_k",  32'(bus.out_k),  32'(lk));
            check("hold_l",  32'(bus.out_l),  32'(ll));
            check("hold_kl", 32'(bus.out_kl), 32'(lkl));
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        mk             = 5;
        ml             = 10;
        aresetn        = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.cfg_kdelay = '0;
        bus.cfg_ldelay = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        aresetn = 1'b1;

        // Defaults k=5 l=10 on DEPTH 16: out_kl = x-15 across wraps, fill saturates at 15
        for (int i = 1; i <= 50; i++) sample(16'(i - 20));
        idle(2);
        @(negedge clk);
        check("fill_saturate", 32'(bus.fill_count), 15);

        // k=2 l=3 ramp 1..12 with hand-computed taps
        cfg(2, 3, 1'b0, 16'h0);
        for (int v = 1; v <= 12; v++)
            sample_hand(16'(v), 16'(v > 2 ? v - 2 : 0), 16'(v > 3 ? v - 3 : 0),
                        16'(v > 5 ? v - 5 : 0), (v >= 6));
        idle(2);

        // Gapped 1-0-0-1 stream: delay counts samples, taps hold in gaps
        cfg(2, 3, 1'b0, 16'h0);
        for (int i = 0; i < 24; i++) begin
            if ((i % 4 == 0) || (i % 4 == 3)) sample(16'(16'h100 + i));
            else idle(1);
        end
        idle(2);
        @(negedge clk);
        chk_fill("gap_fill");

        // Rejected loads leave k/l/fill/state alone; the later sample still uses k=2 l=3
        cfg(0, 5, 1'b0, 16'h0);
        cfg(8, 8, 1'b0, 16'h0);
        sample(16'h0abc);
        idle(2);
        cfg(4, 4, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) sample(16'(16'hf000 + i));
        idle(2);

        // Accepted load with a same-cycle sample: that sample is sample 0
        cfg(1, 1, 1'b1, 16'd9);
        sample(16'd20);
        sample(16'd30);
        idle(2);
        @(negedge clk);
        chk_fill("load_with_sample_fill");

        // Mid-stream asynchronous reset clears everything, including cfg_err and pending out_valid
        cfg(0, 3, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) sample(16'(16'h7700 + i));
        @(posedge clk); #3;
        aresetn      = 1'b0;
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
        q.delete();
        hist.delete();
        mk = 5;
        ml = 10;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int i = 1; i <= 18; i++) sample(16'(16'h0500 + i));
        idle(3);

        check("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
